// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI transaction sequencer: FSM encoding and timing defaults.
package spi_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_XFER  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  // Default CS setup / hold / gap, in ena ticks
  localparam int unsigned DEF_SETUP = 1;
  localparam int unsigned DEF_HOLD  = 1;
  localparam int unsigned DEF_GAP   = 2;

  // Smallest legal clk cycles per ena tick
  localparam int unsigned MIN_DIV   = 2;

endpackage

// File: rtl/spi_ena_gen.sv
// Divider producing the 2xSCK enable tick for SPI_Master.
// With SPI_SEQ_CTRL_DIV_EN defined the divide ratio comes from div_i (0/1 read as 2)
// and is picked up at each counter wrap; otherwise it is the DIV parameter.
module spi_ena_gen
  import spi_seq_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
`ifdef SPI_SEQ_CTRL_DIV_EN
  input  logic [7:0] div_i,
`endif
  output logic       ena_o
);

`ifdef SPI_SEQ_CTRL_DIV_EN
  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] div_eff;
  logic [CNT_W-1:0] lim_q;
  logic [CNT_W-1:0] lim_d;

  // Clamp the runtime ratio and adopt it only when the counter wraps
  always_comb begin
    div_eff = (div_i < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_i;
    lim_d   = ena_o ? (div_eff - CNT_W'(1)) : lim_q;
  end

  // Active terminal count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lim_q <= CNT_W'(MIN_DIV - 1);
    else         lim_q <= lim_d;
  end
`else
  localparam int unsigned CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] lim_d;

  // Fixed terminal count
  assign lim_d = CNT_W'(DIV - 1);
`endif

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ena_d;

  // Next count: restart on wrap or on a master start; tick flagged at terminal count
  always_comb begin
    cnt_d = (clr_i || ena_o) ? '0 : cnt_q + CNT_W'(1);
    ena_d = (cnt_d == lim_d);
  end

  // Counter and registered tick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ena_o <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ena_o <= ena_d;
    end
  end

endmodule

// File: rtl/spi_seq_ctrl.sv
// Transaction sequencer in front of SPI_Master: owns slave select, generates the
// 2xSCK enable and frames a (len+1)-byte transfer with CS setup, hold and gap.
// Optional runtime divider port div_i is enabled by SPI_SEQ_CTRL_DIV_EN.
module spi_seq_ctrl
  import spi_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SS_N   = 4,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned DIV    = 4,
  parameter int unsigned SETUP  = DEF_SETUP,
  parameter int unsigned HOLD   = DEF_HOLD,
  parameter int unsigned GAP    = DEF_GAP,
  localparam int unsigned SS_W  = (SS_N > 1) ? $clog2(SS_N) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [SS_W-1:0]   cmd_ss_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              rx_valid_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              done_o,
  output logic [SS_N-1:0]   ss_n_o,
  output logic              spi_ena_o,
  output logic              spi_start_o,
  output logic              spi_ack_o,
  output logic [DATA_W-1:0] spi_tx_o,
  input  logic [DATA_W-1:0] spi_rx_i,
  input  logic              spi_busy_i,
  input  logic              spi_irq_i
`ifdef SPI_SEQ_CTRL_DIV_EN
  ,
  input  logic [7:0]        div_i
`endif
);

  localparam int unsigned TICK_MAX = (SETUP > HOLD) ? ((SETUP > GAP) ? SETUP : GAP)
                                                    : ((HOLD > GAP) ? HOLD : GAP);
  localparam int unsigned TICK_W   = $clog2(TICK_MAX + 1);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  bcnt_q, bcnt_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [SS_N-1:0]   ss_n_q, ss_n_d;
  logic [SS_N-1:0]   sel;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              tx_ready_q, tx_ready_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic              tick_adv;
  logic              xfer_hit;
  logic              ena;

  // Busy is not needed: the irq/ack handshake fully paces each byte
  logic unused_busy;
  assign unused_busy = spi_busy_i;

  // Enable tick generator, phase restarted by each master start
  spi_ena_gen #(
    .DIV   (DIV)
  ) u_ena_gen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (start_q),
`ifdef SPI_SEQ_CTRL_DIV_EN
    .div_i (div_i),
`endif
    .ena_o (ena)
  );

  // One-hot decode of the requested slave; out-of-range indices select nothing
  always_comb begin
    sel = '0;
    for (int i = 0; i < SS_N; i++) begin
      sel[i] = (int'(cmd_ss_i) == i);
    end
  end

  // Byte completion: RX pulse and ack happen in the master's irq cycle
  assign xfer_hit = (state_q == ST_XFER) && spi_irq_i;

  // Next-state and registered-output decode
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    bcnt_d   = bcnt_q;
    ss_n_d   = ss_n_q;
    tx_d     = tx_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    tick_adv = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          len_d   = cmd_len_i;
          bcnt_d  = '0;
          ss_n_d  = ~sel;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (ena) begin
          if (tick_q == TICK_W'(SETUP - 1)) state_d = ST_LOAD;
          else                              tick_adv = 1'b1;
        end
      end
      ST_LOAD: begin
        if (tx_valid_i && tx_ready_q) begin
          tx_d    = tx_data_i;
          start_d = 1'b1;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (xfer_hit) begin
          if (bcnt_q == len_q) begin
            state_d = ST_HOLD;
          end else begin
            bcnt_d  = bcnt_q + LEN_W'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (ena) begin
          if (tick_q == TICK_W'(HOLD - 1)) begin
            ss_n_d  = '1;
            state_d = ST_GAP;
          end else begin
            tick_adv = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (ena) begin
          if (tick_q == TICK_W'(GAP - 1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tick_adv = 1'b1;
          end
        end
      end
      default: begin
        ss_n_d  = '1;
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) tick_d = '0;
    else if (tick_adv)      tick_d = tick_q + TICK_W'(1);
    else                    tick_d = tick_q;

    ready_d    = (state_d == ST_IDLE);
    tx_ready_d = (state_d == ST_LOAD);
  end

  // State and output registers; reset releases CS at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      bcnt_q     <= '0;
      tick_q     <= '0;
      ss_n_q     <= '1;
      tx_q       <= '0;
      ready_q    <= 1'b0;
      tx_ready_q <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      bcnt_q     <= bcnt_d;
      tick_q     <= tick_d;
      ss_n_q     <= ss_n_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      tx_ready_q <= tx_ready_d;
      start_q    <= start_d;
      done_q     <= done_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign tx_ready_o  = tx_ready_q;
  assign done_o      = done_q;
  assign ss_n_o      = ss_n_q;
  assign spi_ena_o   = ena;
  assign spi_start_o = start_q;
  assign spi_tx_o    = tx_q;
  assign spi_ack_o   = xfer_hit;
  assign rx_valid_o  = xfer_hit;
  assign rx_data_o   = xfer_hit ? spi_rx_i : '0;

endmodule

// File: doc/spi_seq_ctrl.md
# spi_seq_ctrl

Transaction sequencer that drives one `SPI_Master` instance: generates its 2×SCK enable, owns slave-select, and turns a host command (slave index + byte count) into a framed multi-byte SPI transfer. TX bytes are pulled per byte and RX bytes pushed per byte, with programmable CS setup, hold and gap. Sits between the register/bus front-end and `SPI_Master`.

## Interface
- `DATA_W`, 8: byte width, equal to `SPI_Master` `DATA_W`
- `SS_N`, 4: number of slave-select lines
- `LEN_W`, 8: command length field width; a transfer carries `len+1` bytes
- `DIV`, 4: fixed clk_i cycles per ena tick (≥2), used when the divider macro is absent
- `SETUP`, 1 / `HOLD`, 1 / `GAP`, 2: CS setup, hold and deassert-gap, in ena ticks (≥1)
- `clk_i` in 1: system clock
- `rst_ni` in 1: asynchronous, active-low reset
- `cmd_valid_i` in 1 / `cmd_ready_o` out 1: command handshake
- `cmd_ss_i` in $clog2(SS_N): slave index
- `cmd_len_i` in LEN_W: byte count minus one
- `tx_valid_i` in 1 / `tx_ready_o` out 1 / `tx_data_i` in DATA_W: TX byte stream
- `rx_valid_o` out 1 / `rx_data_o` out DATA_W: RX byte stream, one-cycle pulse, no backpressure
- `done_o` out 1: one-cycle pulse when the transfer ends (after gap)
- `ss_n_o` out SS_N: active-low selects
- `spi_ena_o`, `spi_start_o`, `spi_ack_o` out 1; `spi_tx_o` out DATA_W: to master
- `spi_rx_i` in DATA_W, `spi_busy_i` in 1, `spi_irq_i` in 1: from master
- `div_i` in 8: runtime divider, present only with `SPI_SEQ_CTRL_DIV_EN`

## Operation
- States: IDLE, SETUP, LOAD, XFER, HOLD, GAP.
- IDLE: `cmd_ready_o`=1. Handshake latches ss and len, clears byte counter, goes to SETUP; selected `ss_n_o` bit goes low next cycle.
- SETUP: count SETUP ena ticks, then LOAD.
- LOAD: `tx_ready_o`=1. On `tx_valid_i`, register `tx_data_i` into `spi_tx_o`, pulse `spi_start_o` one cycle, go to XFER. TX underrun stalls here with CS held low, without limit.
- XFER: wait for `spi_irq_i`. In that cycle: `rx_valid_o`=1, `rx_data_o`=`spi_rx_i`, `spi_ack_o`=1. If byte counter == len, go to HOLD; else increment and go to LOAD.
- HOLD: count HOLD ena ticks, then deassert all `ss_n_o` and go to GAP.
- GAP: count GAP ticks, pulse `done_o`, return to IDLE.
- Ena generator: counter 0..D-1, `spi_ena_o`=1 when count==D-1. Counter is forced to 0 in the cycle `spi_start_o` is high, matching the master's single-cycle-start rule. D is DIV or `div_i`.
- Tick counter is shared by SETUP, HOLD and GAP, and is cleared on every state entry.
- A `cmd_ss_i` ≥ SS_N selects no line. The transfer still runs, so the bus stays deterministic.

## Timing
- Reset values: `ss_n_o` all ones; `cmd_ready_o`=0 during reset, 1 from the first cycle after release; all other outputs 0. State returns to IDLE.
- Reset mid-transfer releases CS immediately (asynchronous). The master's own reset is handled by the integrator.
- `spi_start_o` is registered: high exactly one cycle after TX acceptance.
- RX pulse, ack and next-state decision all occur in the `spi_irq_i` cycle. The next `tx_ready_o` appears the following cycle.
- CS low → first SCK edge ≥ SETUP ena ticks. Last SCK edge → CS high ≥ HOLD ticks + master STOP half-period.
- CS high → next CS low ≥ GAP ticks + 1 clk.
- `cmd_valid_i` outside IDLE is ignored (ready low). `tx_valid_i` outside LOAD is ignored.
- len = max (255) transfers 256 bytes. The counter is LEN_W bits and does not wrap before the compare.

## Configuration
- `SPI_SEQ_CTRL_DIV_EN` defined: `div_i` port exists and is sampled each cycle. Values 0 and 1 are treated as 2. A change takes effect at the next counter wrap.
- Not defined: no `div_i` port; D = DIV parameter, constant.

## Structure
- Shared package `spi_seq_pkg`: state encoding constants, default SETUP/HOLD/GAP, the minimum-divider constant 2.
- One natural sub-module, `spi_ena_gen`: divider counter with synchronous clear input and optional runtime divide. The FSM stays in `spi_seq_ctrl`.

## Test plan
- DIV=4, mode 0, cmd ss=1 len=0, TX 0xA5, loopback MISO=MOSI → `ss_n_o`=4'b1101 during transfer, one `rx_valid_o` with 0xA5, one `done_o`, `ss_n_o`=4'hF afterwards.
- len=2, TX 0x01/0x02/0x03 fed back-to-back → three starts, three RX pulses, CS low continuously, `done_o` only after the third.
- TX stall: withhold byte 2 for 50 cycles → CS stays low, no `spi_start_o`, and the transfer resumes correctly when the byte arrives.
- Reset asserted during the fourth SCK of byte 0 → `ss_n_o`=4'hF and `cmd_ready_o`=0 asynchronously; after release, a fresh len=0 command completes normally.
- Two commands issued back-to-back → second CS falling edge ≥ GAP×DIV+1 clk after the first rising edge; `cmd_ready_o` low throughout the first.
- With `SPI_SEQ_CTRL_DIV_EN`, `div_i`=1 → `spi_ena_o` period 2 clk; `div_i`=10 → period 10 clk, and the phase restarts at `spi_start_o`.
